// File: rtl/conv_col_drain.sv
// conv_col_drain: counts beats per output window, aligns acc_clear to the
// conv_col pipeline, then biases, rectifies and requantises each window's
// accumulator and queues the byte in a small FIFO with credit back-pressure.
module conv_col_drain #(
   parameter int TAPS  = 33,
   parameter int SHIFT = 8,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        acc_clear,
   input  logic [22:0] acc,
   input  logic [22:0] bias,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        win_busy
);

   localparam int CW = $clog2(TAPS);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 3;
   localparam logic [CW-1:0] LAST_BEAT = CW'(TAPS - 1);
   localparam logic [24:0]   ROUND     = 25'd1 << (SHIFT - 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] beat_cnt;
   logic          accepted;
   logic          first;
   logic          last;
   logic          first_d1;
   logic          last_d1;
   logic          last_d2;
   logic          last_d3;
   logic [24:0]   sum;
   logic [24:0]   rounded;
   logic [24:0]   shifted;
   logic [7:0]    result;
   logic          post_valid;
   logic [7:0]    post_data;
   logic [2:0]    inflight;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_count;
   logic          push;
   logic          pop;
   logic [OW-1:0] occupancy;

   assign accepted = in_valid && in_ready;
   assign first    = accepted && (beat_cnt == '0);
   assign last     = accepted && (beat_cnt == LAST_BEAT);
   assign win_busy = (state == ACCUM);

   // A result slot is reserved for every window from its last beat until the
   // push, so accepting beats only while credits remain makes overflow impossible.
   assign occupancy = OW'(fifo_count) + OW'(inflight);
   assign in_ready  = (occupancy < OW'(DEPTH));

   // Requantisation: 25 bits leave headroom for the rounding constant.
   assign sum     = {{2{acc[22]}}, acc} + {{2{bias[22]}}, bias};
   assign rounded = sum + ROUND;
   assign shifted = rounded >> SHIFT;
   assign result  = sum[24] ? 8'd0 : ((|shifted[24:8]) ? 8'hFF : shifted[7:0]);

   assign push      = post_valid;
   assign pop       = out_valid && out_ready;
   assign out_valid = (fifo_count != '0);
   assign out_data  = mem[rd_ptr];

   // Beat position within the current window, wrapping after the last tap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (accepted) begin
         beat_cnt <= last ? '0 : beat_cnt + CW'(1);
      end
   end

   // Window state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Enter ACCUM on the first accepted beat, leave on the last one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accepted) state_next = ACCUM;
         ACCUM:   if (last)     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Tag delay line tracking beats through the 3-stage conv_col pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_d1  <= 1'b0;
         acc_clear <= 1'b0;
         last_d1   <= 1'b0;
         last_d2   <= 1'b0;
         last_d3   <= 1'b0;
      end else begin
         first_d1  <= first;
         acc_clear <= first_d1;
         last_d1   <= last;
         last_d2   <= last_d1;
         last_d3   <= last_d2;
      end
   end

   // Capture the finished accumulator with bias, ReLU and saturation applied.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         post_valid <= 1'b0;
         post_data  <= '0;
      end else begin
         post_valid <= last_d3;
         if (last_d3) begin
            post_data <= result;
         end
      end
   end

   // Windows whose last beat is in but whose result has not reached the FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= '0;
      end else begin
         inflight <= inflight + {2'b00, last} - {2'b00, push};
      end
   end

   // Output FIFO: registered storage, head visible the cycle after a push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= post_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

endmodule

// File: tb/tb_conv_col_drain.sv
// Testbench for conv_col_drain: table of windows with known results, hand
// sequences for gaps, back-pressure and reset, then randomized traffic
// against a transaction-level reference model.
module tb_conv_col_drain;

   localparam int TAPS  = 3;
   localparam int SHIFT = 8;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        acc_clear;
   logic [22:0] acc_m;
   logic [22:0] bias;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        win_busy;

   logic [22:0] prod_in = '0;
   logic [22:0] mem_r   = '0;
   logic [22:0] prd     = '0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int clr_seen    = 0;
   int acc_beats   = 0;
   int bias_val    = 0;

   // Reference model state: beats into current window, running window sum,
   // pending results with the cycle they should be pushed, FIFO contents,
   // and the cycles on which acc_clear is due.
   int mbeat = 0;
   int wsum  = 0;
   int pend_val[$];
   int pend_due[$];
   int mfifo[$];
   int clr_q[$];

   typedef struct {
      int p0;
      int p1;
      int p2;
      int bval;
      bit gap;
      int exp;
   } vec_t;

   vec_t tbl[9];

   conv_col_drain #(
      .TAPS (TAPS),
      .SHIFT(SHIFT),
      .DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .acc_clear(acc_clear),
      .acc      (acc_m),
      .bias     (bias),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .win_busy (win_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural conv_col: product registered, then accumulated (or reloaded on clear).
   always @(posedge clk) begin
      mem_r <= (in_valid && in_ready) ? prod_in : '0;
      prd   <= mem_r;
      acc_m <= acc_clear ? prd : acc_m + prd;
   end

   function automatic int ref_out(input int s);
      int t;
      t = s + bias_val;
      if (t < 0) return 0;
      t = (t + (1 << (SHIFT - 1))) >>> SHIFT;
      if (t > 255) return 255;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_bias(input int b);
      bias_val = b;
      bias     = 23'(b);
   endtask

   task automatic model_clear();
      mbeat = 0;
      wsum  = 0;
      pend_val.delete();
      pend_due.delete();
      mfifo.delete();
      clr_q.delete();
   endtask

   // One clock cycle: check outputs against the model, drive inputs, advance the model.
   task automatic applyStimulus(input bit v, input int p, input bit ordy);
      bit exp_ir;
      bit exp_ov;
      bit exp_clr;
      bit acc_now;
      exp_ir  = (mfifo.size() + pend_val.size()) < DEPTH;
      exp_ov  = (mfifo.size() != 0);
      exp_clr = (clr_q.size() != 0) && (clr_q[0] == cyc);
      if (exp_clr) void'(clr_q.pop_front());
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ir));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) checkOutput("out_data", 32'(out_data), mfifo[0]);
      checkOutput("acc_clear", 32'(acc_clear), 32'(exp_clr));
      checkOutput("win_busy", 32'(win_busy), 32'(mbeat != 0));
      if (acc_clear === 1'b1) clr_seen++;

      in_valid  = v;
      prod_in   = 23'(p);
      out_ready = ordy;
      if (v && in_ready === 1'b1) acc_beats++;
      acc_now = v && exp_ir;

      if (ordy && exp_ov) void'(mfifo.pop_front());
      while (pend_due.size() != 0 && pend_due[0] == cyc) begin
         mfifo.push_back(pend_val.pop_front());
         void'(pend_due.pop_front());
      end
      if (acc_now) begin
         if (mbeat == 0) clr_q.push_back(cyc + 2);
         wsum += p;
         if (mbeat == TAPS - 1) begin
            pend_val.push_back(ref_out(wsum));
            pend_due.push_back(cyc + 4);
            wsum  = 0;
            mbeat = 0;
         end else begin
            mbeat++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_vec(input vec_t t);
      int n;
      int clr0;
      clr0 = clr_seen;
      set_bias(t.bval);
      applyStimulus(1'b1, t.p0, 1'b0);
      applyStimulus(1'b1, t.p1, 1'b0);
      if (t.gap) begin
         applyStimulus(1'b0, 0, 1'b0);
         applyStimulus(1'b0, 0, 1'b0);
      end
      applyStimulus(1'b1, t.p2, 1'b0);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         applyStimulus(1'b0, 0, 1'b0);
         n++;
      end
      checkOutput("latency", 32'(n), 32'd4);
      checkOutput("result", 32'(out_data), 32'(t.exp));
      applyStimulus(1'b0, 0, 1'b1);
      checkOutput("clear_once", 32'(clr_seen - clr0), 32'd1);
   endtask

   initial begin
      int b0;
      tbl[0] = '{400, 300, 300, 0, 1'b0, 4};
      tbl[1] = '{-200, -200, -100, 300, 1'b0, 0};
      tbl[2] = '{50000, 30000, 20000, 0, 1'b0, 255};
      tbl[3] = '{400, 300, 300, 0, 1'b1, 4};
      tbl[4] = '{100, 20, 8, 0, 1'b0, 1};
      tbl[5] = '{100, 20, 7, 0, 1'b0, 0};
      tbl[6] = '{30000, 30000, 5151, 0, 1'b0, 254};
      tbl[7] = '{30000, 30000, 5152, 0, 1'b0, 255};
      tbl[8] = '{10, 10, 10, 2000, 1'b0, 8};

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_bias(0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_acc_clear", 32'(acc_clear), 32'd0);
      checkOutput("rst_win_busy", 32'(win_busy), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // Back-to-back windows with the consumer stalled: only DEPTH windows fit.
      set_bias(0);
      b0 = acc_beats;
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 10000 + i * 2000, 1'b0);
      checkOutput("b2b_beats", 32'(acc_beats - b0), 32'(DEPTH * TAPS));
      checkOutput("b2b_stall", 32'(in_ready), 32'd0);
      b0 = acc_beats;
      applyStimulus(1'b1, 5, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 20000 + i * 1500, 1'b0);
      checkOutput("b2b_extra", 32'(acc_beats - b0), 32'(TAPS));
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 0, 1'b1);

      // Reset in the middle of a window with a result already queued.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 700, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b1, 9999, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_out_data", 32'(out_data), 32'd0);
      checkOutput("abort_acc_clear", 32'(acc_clear), 32'd0);
      checkOutput("abort_win_busy", 32'(win_busy), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      cyc++;
      run_vec(tbl[0]);

      // Randomized traffic against the reference model.
      set_bias(int'($urandom_range(0, 100000)) - 50000);
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(0, 9) < 6), int'($urandom_range(0, 200000)) - 100000,
                       $urandom_range(0, 1) == 1);
      end
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 0, 1'b1);
      checkOutput("drained", 32'(out_valid), 32'd0);
      checkOutput("idle_ready", 32'(in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
